instr_encoder_loader: RTL

- Encodes decoded instruction fields back into 32-bit RISC-V machine words for the processor's supported subset: R-type, I-type ALU, load, store and branch.
- Writes the words sequentially into instruction memory.
- Sits between the testbench or program-load path and the instruction memory. It is the encoding counterpart of the control unit's decoding of Op/funct3/funct7, so any program it loads must decode back to the same fields.
- Uses a valid/ready input handshake, a one-stage encode pipeline, and a small load state machine.

---
 rtl/instr_encoder_loader_if.sv | 28 ++
 rtl/instr_encoder_loader.sv | 108 ++++++++++
 2 files changed

// File: rtl/instr_encoder_loader_if.sv
// Request bundle for instr_encoder_loader.
// One valid/ready transfer carries one decoded instruction's fields.
//   in_valid   producer has a request
//   in_ready   loader accepts the request this cycle
//   in_kind    0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5..7 illegal
//   in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm  instruction fields
// The master modport is the producer side; the slave modport is the loader side.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes decoded RISC-V fields (R, I-ALU, LOAD, STORE, BRANCH) into 32-bit
// machine words and writes them sequentially into instruction memory.
//   clk, rst      clock and synchronous active-high reset
//   start         pulse: begin a load at word address 0 (clears count and err)
//   finish        pulse: end the current load (done pulses next cycle)
//   req           request bundle (valid/ready handshake plus fields)
//   mem_we/addr/wdata  instruction-memory write port, one cycle after transfer
//   count         legal words accepted in the current load
//   full          count has reached DEPTH; no more transfers until start
//   err           sticky flag for illegal requests
//   done          one-cycle pulse when a load ends
module instr_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  finish,
  instr_encoder_loader_if.slave req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state_q, state_d;
  logic        ready;
  logic        xfer;
  logic        legal;
  logic        we_q;
  logic [31:0] enc;

  assign full         = (count == DEPTH);
  assign req.in_ready = ready;
  assign xfer         = req.in_valid && ready;
  // A registered write is dropped while rst is high rather than being
  // allowed to land during the reset cycle.
  assign mem_we       = we_q && !rst;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    if (start)
      state_d = LOAD;
    else if (finish && state_q == LOAD)
      state_d = IDLE;
    ready = (state_q == LOAD) && !start && !finish && !full;
  end

  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (req.in_kind)
      3'd0: enc = {req.in_funct7, req.in_rs2, req.in_rs1, req.in_funct3,
                   req.in_rd, 7'b0110011};
      3'd1: enc = {req.in_imm[11:0], req.in_rs1, req.in_funct3,
                   req.in_rd, 7'b0010011};
      3'd2: enc = {req.in_imm[11:0], req.in_rs1, req.in_funct3,
                   req.in_rd, 7'b0000011};
      3'd3: enc = {req.in_imm[11:5], req.in_rs2, req.in_rs1, req.in_funct3,
                   req.in_imm[4:0], 7'b0100011};
      3'd4: begin
        enc   = {req.in_imm[12], req.in_imm[10:5], req.in_rs2, req.in_rs1,
                 req.in_funct3, req.in_imm[4:1], req.in_imm[11], 7'b1100011};
        // Branch offsets are in bytes but must be halfword aligned.
        legal = !req.in_imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= xfer && legal;
      done    <= (state_q == LOAD) && finish && !start;
      if (xfer && legal) begin
        mem_addr  <= count[ADDR_WIDTH-1:0];
        mem_wdata <= enc;
        count     <= count + (ADDR_WIDTH+1)'(1);
      end
      if (xfer && !legal)
        err <= 1'b1;
      // start blocks transfers in its own cycle, so these never collide
      // with the updates above.
      if (start) begin
        count <= '0;
        err   <= 1'b0;
      end
    end
  end

endmodule
